multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Moore-style control FSM for a multicycle RV32I core sharing one ALU and one unified
//  memory port. Consumes op/funct3 from the instruction register and ALU flags.
//  Emits per-cycle mux selects, register/PC/IR write enables and a req/ready memory handshake.
//  Feeds ALUOp to the existing alu_decoder. Latches illegal-opcode and bus-timeout traps.
// PARAMETERS
//  TIMEOUT   255  max cycles a memory request may wait for mem_ready before bus_err trap
//  CNT_W     8    width of wait counter; must hold TIMEOUT
// PORTS
//  clk        in   1  rising-edge clock
//  reset      in   1  asynchronous, active-high; sets state to FETCH and clears traps
//  op         in   7  instr[6:0] from IR
//  funct3     in   3  instr[14:12] from IR
//  Zero       in   1  ALU result == 0
//  ALUR31     in   1  ALU result bit 31 (signed less-than for blt/bge)
//  mem_ready  in   1  memory completes the current access this cycle
//  mem_req    out  1  memory access request
//  MemWrite   out  1  store strobe; valid only while mem_req=1
//  AdrSrc     out  1  0: address = PC; 1: address = ALUOut
//  IRWrite    out  1  load IR and OldPC
//  PCWrite    out  1  PCUpdate | (Branch & take)
//  RegWrite   out  1  register-file write enable
//  ALUSrcA    out  2  00 PC, 01 OldPC, 10 rs1 register
//  ALUSrcB    out  2  00 rs2 register, 01 ImmExt, 10 const 4
//  ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result, 11 U-type path
//  ALUOp      out  2  00 add, 01 sub/compare, 10 funct-decoded
//  ImmSrc     out  2  combinational from op: I=00, S=01, B=10, J=11
//  illegal    out  1  sticky: undecodable opcode
//  bus_err    out  1  sticky: memory wait hit TIMEOUT
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0, illegal=bus_err=0.
//   Outputs then take their FETCH values, so mem_req=1 immediately.
//  Outputs: all are decoded from state, except PCWrite, which also uses the branch condition.
//   Unlisted strobes are 0. Selects not listed in a state are don't-care (drive 00).
//  States and outputs:
//   FETCH: mem_req; AdrSrc=0; A=00, B=10, ALUOp=00, ResultSrc=10.
//     When mem_ready: IRWrite=1, PCUpdate=1, next state DECODE. Otherwise hold.
//   DECODE: A=01, B=01, ALUOp=00 (ALUOut <= branch/jal target).
//     Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI;
//     1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0x10111 -> UWB;
//     any other op -> TRAP with illegal=1.
//   MEMADR: A=10, B=01, ALUOp=00. Next: MEMREAD if op[5]=0, else MEMWRITE.
//   MEMREAD: mem_req, AdrSrc=1. Hold until mem_ready, then MEMWB.
//   MEMWB: ResultSrc=01, RegWrite. Next FETCH.
//   MEMWRITE: mem_req, MemWrite, AdrSrc=1. Hold until mem_ready, then FETCH.
//   EXECR: A=10, B=00, ALUOp=10. Next ALUWB.
//   EXECI: A=10, B=01, ALUOp=10. Next ALUWB.
//   ALUWB: ResultSrc=00, RegWrite. Next FETCH.
//   BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00, Branch=1. Next FETCH.
//     take: beq=Zero, bne=!Zero, blt=ALUR31, bge=!ALUR31; other funct3 -> take=0.
//   JAL: A=01, B=10, ALUOp=00, ResultSrc=00, PCUpdate. Next ALUWB (rd <= OldPC+4).
//   JALR: A=10, B=01, ALUOp=00, ResultSrc=10, PCUpdate. Next JALRWB.
//   JALRWB: A=01, B=10, ALUOp=00, ResultSrc=10, RegWrite. Next FETCH.
//   UWB: ResultSrc=11, RegWrite. Next FETCH.
//   TRAP: all strobes and mem_req=0. Absorbing; only reset exits.
//  Latency with mem_ready=1 on first request cycle:
//   branch 3, lui/auipc 3, R/I/jal/jalr/sw 4, lw 5 cycles.
//  Wait counter: clears on entering any mem_req state; increments each mem_req & !mem_ready cycle.
//   When count==TIMEOUT and mem_ready=0: next state TRAP, bus_err=1.
//   mem_ready on that same cycle wins: no trap.
//  mem_req stays high, and AdrSrc/MemWrite stay stable, for every cycle until mem_ready.
//  Reset mid-access: mem_req and MemWrite drop asynchronously; no partial writeback.
// STRUCTURE
//  Package riscv_ctrl_pkg: state encodings, opcode constants, ALUSrcA/B, ResultSrc and
//   ALUOp encodings, funct3 branch codes.
//  One sub-module branch_resolve (funct3, Zero, ALUR31 -> take), shared with single-cycle decoder.
// TESTING
//  1 add (op=0110011), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB.
//    RegWrite=1 only in cycle 4; ALUOp=10 in cycle 3.
//  2 lw, mem_ready low 3 cycles in MEMREAD -> mem_req/AdrSrc=1 held 4 cycles, then MEMWB.
//    Total 8 cycles.
//  3 beq, Zero=1 -> PCWrite=1 in BRANCH. Repeat with Zero=0 -> PCWrite=0.
//    bge with ALUR31=0 -> taken.
//  4 op=0000000 -> TRAP after DECODE, illegal=1; no further mem_req until reset.
//    Then reset -> FETCH, illegal=0.
//  5 TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_err=1 and TRAP on cycle 5.
//    mem_ready=1 on cycle 5 -> no trap.
//  6 reset asserted mid-MEMWRITE -> MemWrite=0 same cycle, state FETCH.
//    jalr then completes in 4 cycles with PCWrite in cycle 3, RegWrite in cycle 4.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// datapath select codes and branch funct3 values.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        JALR,
        JALRWB,
        UWB,
        TRAP
    } ctrlState_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_UTYPE  = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/multicycle_controller_branch_resolve.sv
// Branch condition from funct3 and ALU flags; also reused by the single-cycle decoder.
module branch_resolve
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       ALUR31,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (funct3)
            F3_BEQ:  take = Zero;
            F3_BNE:  take = !Zero;
            F3_BLT:  take = ALUR31;
            F3_BGE:  take = !ALUR31;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32I core with a shared ALU, a unified
// req/ready memory port, and sticky illegal-opcode / bus-timeout traps.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       ALUR31,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal,
    output logic       bus_err
);

    ctrlState_t       state, nextState;
    logic [CNT_W-1:0] waitCnt;
    logic             reqState, memWriteState, pcUpdate, branch, take;
    logic             timedOut, setIllegal, setBusErr;

    branch_resolve uBranch (
        .funct3 (funct3),
        .Zero   (Zero),
        .ALUR31 (ALUR31),
        .take   (take)
    );

    assign timedOut = (waitCnt == CNT_W'(TIMEOUT)) && !mem_ready;

    // Wait counter is zero whenever no access is stalled, so it starts clean on every new request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            waitCnt <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= nextState;
            if (reqState && !mem_ready)
                waitCnt <= waitCnt + 1'b1;
            else
                waitCnt <= '0;
            if (setIllegal)
                illegal <= 1'b1;
            if (setBusErr)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        nextState     = state;
        reqState      = 1'b0;
        memWriteState = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        pcUpdate      = 1'b0;
        branch        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        ResultSrc     = RES_ALUOUT;
        ALUOp         = ALUOP_ADD;
        setIllegal    = 1'b0;
        setBusErr     = 1'b0;
        case (state)
            FETCH: begin
                reqState  = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    pcUpdate  = 1'b1;
                    nextState = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                casez (op)
                    OP_LOAD, OP_STORE: nextState = MEMADR;
                    OP_R:              nextState = EXECR;
                    OP_IMM:            nextState = EXECI;
                    OP_BRANCH:         nextState = BRANCH;
                    OP_JAL:            nextState = JAL;
                    OP_JALR:           nextState = JALR;
                    7'b0?10111:        nextState = UWB;
                    default: begin
                        nextState  = TRAP;
                        setIllegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                nextState = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                reqState = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready)
                    nextState = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_RDATA;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            MEMWRITE: begin
                reqState      = 1'b1;
                memWriteState = 1'b1;
                AdrSrc        = 1'b1;
                if (mem_ready)
                    nextState = FETCH;
            end
            EXECR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ALUOp     = ALUOP_FUNCT;
                nextState = ALUWB;
            end
            EXECI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ALUOp     = ALUOP_FUNCT;
                nextState = ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ALUOp     = ALUOP_SUB;
                branch    = 1'b1;
                nextState = FETCH;
            end
            JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pcUpdate  = 1'b1;
                nextState = ALUWB;
            end
            JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                pcUpdate  = 1'b1;
                nextState = JALRWB;
            end
            JALRWB: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            UWB: begin
                ResultSrc = RES_UTYPE;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            TRAP:    nextState = TRAP;
            default: nextState = FETCH;
        endcase
        // A ready on the final allowed cycle completes the access instead of trapping.
        if (reqState && timedOut) begin
            nextState = TRAP;
            setBusErr = 1'b1;
        end
    end

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    // Bus-facing strobes are gated by reset so an in-flight access is abandoned immediately.
    assign mem_req  = reqState && !reset;
    assign MemWrite = memWriteState && !reset;
    assign PCWrite  = pcUpdate || (branch && take);

endmodule
